ecg_tx_packetizer: RTL and testbench
====================================

ECG_TX_PACKETIZER -- requirements
Module: ecg_tx_packetizer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sample buffer depth in words; power of two, 2..64.
REQ-002 Parameter SYNC_BYTE, default 8'hA5, packet header byte.
REQ-003 Clk  input  1  system clock, 50 MHz.
REQ-004 nRst  input  1  reset, asynchronous, active-low.
REQ-005 sample_valid  input  1  one-cycle strobe; sample is valid this cycle.
REQ-006 sample  input  16  filtered ECG sample, signed two's complement.
REQ-007 tx_busy  input  1  busy flag from the downstream UART transmitter.
REQ-008 tx_start  output  1  one-cycle request to the UART to send tx_data.
REQ-009 tx_data  output  8  byte to transmit.
REQ-010 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of buffered samples.
REQ-011 overflow  output  1  sticky flag; a sample was dropped.

Function
REQ-012 Each sample becomes a 5-byte packet, sent in this order: SYNC_BYTE, seq, sample[15:8], sample[7:0], chk.
REQ-013 seq: 8-bit counter, 0 after reset, incremented once per completed packet, wraps 255->0.
REQ-014 chk = seq XOR sample[15:8] XOR sample[7:0].
REQ-015 Sample buffer: FIFO_DEPTH-entry FIFO; push on sample_valid; pop when the FSM leaves IDLE.
REQ-016 Full FIFO with sample_valid and no pop in the same cycle: sample dropped, overflow set to 1, FIFO contents unchanged.
REQ-017 Full FIFO with sample_valid and pop in the same cycle: push accepted, level unchanged.
REQ-018 Empty FIFO with sample_valid: sample cannot be popped until the following cycle (no bypass).
REQ-019 fifo_level updates on the clock edge after a push or pop; it never exceeds FIFO_DEPTH.
REQ-020 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-021 IDLE: if FIFO is non-empty and tx_busy=0, then pop the FIFO, latch the sample, compute chk, set byte index to 0, and go to ISSUE.
REQ-022 ISSUE: assert tx_start for exactly one cycle with tx_data = byte[index]; go to WAIT_ACK.
REQ-023 WAIT_ACK: wait until tx_busy=1, then go to WAIT_DONE; tx_start stays 0.
REQ-024 WAIT_DONE: wait until tx_busy=0. If index<4, increment index and go to ISSUE. Otherwise increment seq and go to IDLE.
REQ-025 tx_data holds its value from ISSUE until the next ISSUE; tx_start is never asserted while tx_busy=1.
REQ-026 Minimum gap between the tx_busy fall and the next tx_start: 1 cycle. A back-to-back queued sample adds 1 extra IDLE cycle.
REQ-027 Arithmetic: all byte operations are 8-bit unsigned; sample bytes are taken raw, with no sign handling.

Reset
REQ-028 On nRst low, asynchronously: tx_start=0, tx_data=8'h00, FSM=IDLE, index=0, seq=0, FIFO empty, fifo_level=0, overflow=0.
REQ-029 Reset mid-packet abandons the packet with no further tx_start; the partial packet is discarded by the receiver via SYNC/chk.
REQ-030 overflow is cleared only by reset.

Structure
REQ-031 Package ecg_uart_pkg holds SYNC_BYTE default, PKT_LEN=5, and the FSM state enum; it is shared with the receiver-side tools.
REQ-032 The FIFO is a separate sub-module, sample_fifo, parameterised on width and depth and exposing push, pop, dout, empty, full, and level.
REQ-033 Byte selection is a combinational mux on index; no shift register is required.

Verification
REQ-034 Push sample 16'h1234 into an idle block with a UART model -> bytes A5,00,12,34,26 are sent, then seq=1.
REQ-035 Push 16'hFF80 after 255 packets -> seq byte is FF and chk=FF^FF^80=80; the next packet has seq=00.
REQ-036 Push 9 samples in 9 consecutive cycles with FIFO_DEPTH=8 while the UART is busy -> first 8 are kept, 9th dropped, overflow=1, fifo_level=8.
REQ-037 Full FIFO, push coinciding with the IDLE pop -> push accepted, level stays 8, overflow remains 0.
REQ-038 Assert nRst during byte 3 -> all outputs are at reset values immediately; after release the next sample produces a packet with seq=00.
REQ-039 Hold tx_busy high for 10 cycles after tx_start -> no second tx_start until 1 cycle after tx_busy falls; a checker asserts that tx_start and tx_busy are never both 1.

Source files
------------

// File: rtl/ecg_uart_pkg.sv
// rtl/ecg_uart_pkg.sv - shared packet constants and transmitter state encoding
package ecg_uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         PKT_LEN           = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } tx_state_e;

    function automatic logic [7:0] pkt_chk(input logic [7:0] seq, input logic [15:0] s);
        return seq ^ s[15:8] ^ s[7:0];
    endfunction

endpackage

// File: rtl/ecg_tx_packetizer_if.sv
// rtl/ecg_tx_packetizer_if.sv - sample input, UART handshake and status signals
interface ecg_tx_packetizer_if #(
    parameter int LEVEL_W = 4
);
    logic               sample_valid;
    logic [15:0]        sample;
    logic               tx_busy;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic [LEVEL_W-1:0] fifo_level;
    logic               overflow;

    // master is the sample source plus the UART; slave is the packetizer
    modport master (
        output sample_valid, sample, tx_busy,
        input  tx_start, tx_data, fifo_level, overflow
    );

    modport slave (
        input  sample_valid, sample, tx_busy,
        output tx_start, tx_data, fifo_level, overflow
    );
endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - first-word-fall-through FIFO; a push into an empty FIFO is visible next cycle
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   Clk,
    input  logic                   nRst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // a full FIFO still accepts a push when the same cycle frees a slot
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/ecg_tx_packetizer.sv
// rtl/ecg_tx_packetizer.sv - frames each ECG sample as SYNC,seq,hi,lo,chk and hands bytes to a UART
module ecg_tx_packetizer
    import ecg_uart_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                Clk,
    input  logic                nRst,
    ecg_tx_packetizer_if.slave  bus
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e          state_q, state_d;
    logic [2:0]         index_q, index_d;
    logic [7:0]         seq_q, seq_d;
    logic [15:0]        sample_q, sample_d;
    logic [7:0]         chk_q, chk_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               overflow_q, overflow_d;
    logic               pop, load;
    logic               fifo_empty, fifo_full;
    logic [15:0]        fifo_dout;
    logic [LEVEL_W-1:0] fifo_level;

    sample_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .nRst  (nRst),
        .push  (bus.sample_valid),
        .pop   (pop),
        .din   (bus.sample),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    function automatic logic [7:0] sel_byte(input logic [2:0]  idx,
                                            input logic [7:0]  seq,
                                            input logic [15:0] s,
                                            input logic [7:0]  chk);
        case (idx)
            3'd0:    return SYNC_BYTE;
            3'd1:    return seq;
            3'd2:    return s[15:8];
            3'd3:    return s[7:0];
            default: return chk;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        seq_d      = seq_q;
        sample_d   = sample_q;
        chk_d      = chk_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !bus.tx_busy) begin
                    pop      = 1'b1;
                    sample_d = fifo_dout;
                    chk_d    = pkt_chk(seq_q, fifo_dout);
                    index_d  = 3'd0;
                    load     = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (index_q < 3'(PKT_LEN - 1)) begin
                        index_d = index_q + 3'd1;
                        load    = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        seq_d   = seq_q + 8'd1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // tx_start/tx_data are registered so they are high exactly during ISSUE
        if (load) begin
            tx_start_d = 1'b1;
            tx_data_d  = sel_byte(index_d, seq_q, sample_d, chk_d);
        end
    end

    assign overflow_d = overflow_q | (bus.sample_valid & fifo_full & ~pop);

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            seq_q      <= '0;
            sample_q   <= '0;
            chk_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            seq_q      <= seq_d;
            sample_q   <= sample_d;
            chk_q      <= chk_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.fifo_level = fifo_level;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_ecg_tx_packetizer.sv
// tb/tb_ecg_tx_packetizer.sv - scoreboard bench with UART model for ecg_tx_packetizer
module tb_ecg_tx_packetizer;

    typedef struct {
        logic [7:0] data;
        bit         first;
    } exp_t;

    logic Clk = 1'b0;
    logic nRst = 1'b0;
    logic uart_busy = 1'b0;
    logic hold_busy = 1'b0;
    int   uart_len = 3;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] exp_seq = 8'h00;
    int   cyc = 0;
    int   fall_cyc = -100;
    int   starts = 0;
    logic prev_busy = 1'b0;

    always #10 Clk = ~Clk;

    ecg_tx_packetizer_if #(.LEVEL_W(4)) bus ();

    ecg_tx_packetizer #(
        .FIFO_DEPTH (8),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .Clk  (Clk),
        .nRst (nRst),
        .bus  (bus)
    );

    assign bus.tx_busy = uart_busy | hold_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART model: busy rises the cycle after tx_start and stays for uart_len cycles
    initial begin
        forever begin
            @(negedge Clk);
            if (bus.tx_start === 1'b1) begin
                @(posedge Clk);
                #1 uart_busy = 1'b1;
                repeat (uart_len) @(posedge Clk);
                #1 uart_busy = 1'b0;
            end
        end
    end

    // monitor: pops the scoreboard on every tx_start
    always @(negedge Clk) begin
        cyc++;
        if (prev_busy && !bus.tx_busy) fall_cyc = cyc;
        prev_busy = bus.tx_busy;
        if (bus.tx_start === 1'b1) begin
            starts++;
            check("start_while_busy", 32'(bus.tx_busy), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_byte", 32'(bus.tx_data), 32'(mon_e.data));
                if (!mon_e.first) check("gap_after_busy_fall", 32'(cyc - fall_cyc), 32'd1);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
        exp_q.push_back('{b0, 1'b1});
        exp_q.push_back('{b1, 1'b0});
        exp_q.push_back('{b2, 1'b0});
        exp_q.push_back('{b3, 1'b0});
        exp_q.push_back('{b4, 1'b0});
    endtask

    task automatic expect_pkt(input logic [15:0] s);
        push_exp(8'hA5, exp_seq, s[15:8], s[7:0], exp_seq ^ s[15:8] ^ s[7:0]);
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic send(input logic [15:0] s);
        bus.sample       = s;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick(uart_len + 4);
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        tick(2);
        nRst = 1'b1;
        tick(2);
        exp_seq = 8'h00;
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample       = 16'h0000;
        tick(2);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        nRst = 1'b1;
        tick(2);

        // single packet from idle
        push_exp(8'hA5, 8'h00, 8'h12, 8'h34, 8'h26);
        send(16'h1234);
        check("level_no_bypass", 32'(bus.fifo_level), 32'd1);
        wait_drain(300, "drain_1234");
        check("level_after_1234", 32'(bus.fifo_level), 32'd0);

        // long busy: next byte only 1 cycle after busy falls
        uart_len = 10;
        push_exp(8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h67);
        send(16'hABCD);
        wait_drain(600, "drain_abcd");
        uart_len = 3;

        // back-to-back samples, second push meets the IDLE pop
        push_exp(8'hA5, 8'h02, 8'h01, 8'h02, 8'h01);
        push_exp(8'hA5, 8'h03, 8'h80, 8'h00, 8'h83);
        bus.sample       = 16'h0102;
        bus.sample_valid = 1'b1;
        tick();
        check("level_first_push", 32'(bus.fifo_level), 32'd1);
        bus.sample = 16'h8000;
        tick();
        bus.sample_valid = 1'b0;
        check("level_push_pop", 32'(bus.fifo_level), 32'd1);
        wait_drain(600, "drain_b2b");

        // reset in the middle of byte 3
        begin
            int base;
            int n;
            base = starts;
            n = 0;
            push_exp(8'hA5, 8'h04, 8'h5A, 8'h3C, 8'h62);
            send(16'h5A3C);
            send(16'h1111);
            while (starts < base + 3 && n < 300) begin
                tick();
                n++;
            end
            check("reached_byte3", 32'(starts - base), 32'd3);
            tick(1);
            nRst = 1'b0;
            #1;
            check("midrst_tx_start", 32'(bus.tx_start), 32'd0);
            check("midrst_tx_data", 32'(bus.tx_data), 32'h00);
            check("midrst_fifo_level", 32'(bus.fifo_level), 32'd0);
            check("midrst_overflow", 32'(bus.overflow), 32'd0);
            exp_q.delete();
            tick(uart_len + 3);
            nRst = 1'b1;
            tick(3);
            check("no_start_after_rst", 32'(starts - base), 32'd3);
            push_exp(8'hA5, 8'h00, 8'h77, 8'h00, 8'h77);
            send(16'h7700);
            wait_drain(300, "drain_after_rst");
        end

        // 9 pushes into depth 8 while UART busy
        exp_seq = 8'h01;
        hold_busy = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            bus.sample       = 16'hC000 + 16'(i);
            bus.sample_valid = 1'b1;
            tick();
            if (i < 8) expect_pkt(16'hC000 + 16'(i));
        end
        bus.sample_valid = 1'b0;
        check("ovf_level", 32'(bus.fifo_level), 32'd8);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        hold_busy = 1'b0;
        wait_drain(3000, "drain_ovf");
        check("ovf_level_drained", 32'(bus.fifo_level), 32'd0);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // full FIFO push coinciding with the IDLE pop
        do_reset();
        check("ovf_cleared_by_rst", 32'(bus.overflow), 32'd0);
        hold_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.sample       = 16'h3300 + 16'(i);
            bus.sample_valid = 1'b1;
            tick();
            expect_pkt(16'h3300 + 16'(i));
        end
        check("full_level", 32'(bus.fifo_level), 32'd8);
        check("full_no_ovf", 32'(bus.overflow), 32'd0);
        hold_busy  = 1'b0;
        bus.sample = 16'hD00D;
        tick();
        bus.sample_valid = 1'b0;
        expect_pkt(16'hD00D);
        check("full_pushpop_level", 32'(bus.fifo_level), 32'd8);
        check("full_pushpop_ovf", 32'(bus.overflow), 32'd0);
        wait_drain(3000, "drain_full");

        // sequence wrap
        do_reset();
        uart_len = 1;
        for (int i = 0; i < 255; i++) begin
            expect_pkt(16'(i * 3 + 7));
            send(16'(i * 3 + 7));
            wait_drain(200, "drain_bulk");
        end
        push_exp(8'hA5, 8'hFF, 8'hFF, 8'h80, 8'h80);
        send(16'hFF80);
        wait_drain(200, "drain_ff80");
        push_exp(8'hA5, 8'h00, 8'h00, 8'h01, 8'h01);
        send(16'h0001);
        wait_drain(200, "drain_wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "time limit reached");
    end

endmodule
